mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit resource between four requesters, e.g. a single data-memory or bus port used by IF, MEM, debug and DMA.
- Its registered sel output drives the 2-bit select of the existing 4:1 32-bit datapath mux that steers the requester payloads onto the shared port.
- Grants are held until the resource signals completion, the requester withdraws, or a watchdog timeout expires.

---
 rtl/mux4_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter for one shared 32-bit port. The registered sel drives
// the select input of the external 4:1 payload mux. A grant is held until done, until
// the owner withdraws its request, or until the hold watchdog expires.
// Optional build macro: ARB_LOCK_EN adds a lock input that keeps the grant across
// consecutive transactions (atomic sequences).
module mux4_rr_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic             terr_q, terr_d;

  logic       owner_req;
  logic       wd_expired;
  logic       hold_lock;
  logic       release_now;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;

  // Returns {found, index}: first set request bit searching upward from ptr+1.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (r[idx] && !res[2]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign owner_req  = req[sel_q];
  assign wd_expired = (cnt_q == CntLast);

`ifdef ARB_LOCK_EN
  assign hold_lock = done & lock & owner_req;
`else
  assign hold_lock = 1'b0;
`endif

  // done has priority over withdraw, which has priority over the watchdog.
  assign release_now = done | ~owner_req | wd_expired;

  // Idle picks from the stored pointer; a release picks as if last_ptr were already sel.
  assign pick_idle = rr_pick(last_q, req);
  assign pick_rel  = rr_pick(sel_q, req);

  // Next-state: arbitration, hold, lock retention and watchdog release.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    terr_d  = 1'b0;
    if (state_q == StIdle) begin
      if (pick_idle[2]) begin
        state_d = StGrant;
        sel_d   = pick_idle[1:0];
        gnt_d   = 4'b0001 << pick_idle[1:0];
        cnt_d   = '0;
      end else begin
        gnt_d = 4'b0000;
      end
    end else if (hold_lock) begin
      cnt_d = '0;
    end else if (release_now) begin
      last_d = sel_q;
      terr_d = ~done & owner_req;
      if (pick_rel[2]) begin
        sel_d = pick_rel[1:0];
        gnt_d = 4'b0001 << pick_rel[1:0];
        cnt_d = '0;
      end else begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign busy        = (state_q == StGrant);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model built from the round-robin rules.
module tb_mux4_rr_arbiter;

  localparam int TIMEOUT = 15;
`ifdef ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       lock;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout_err;

  int errors;
  int checks;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_terr;
  int tmo_pulses;

  mux4_rr_arbiter #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
`ifdef ARB_LOCK_EN
    .lock       (lock),
`endif
    .sel        (sel),
    .gnt        (gnt),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int next_winner(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model over one rising edge given the inputs present before it.
  task automatic model_edge(input logic [3:0] r, input logic d, input logic l,
                            input logic rn);
    int w;
    if (!rn) begin
      m_busy = 0; m_owner = 0; m_last = 3; m_cnt = 0; m_terr = 0;
    end else if (!m_busy) begin
      m_terr = 0;
      w = next_winner(m_last, r);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_cnt = 0;
      end
    end else if (LockEn && d && l && r[m_owner]) begin
      m_terr = 0; m_cnt = 0;
    end else if (d || !r[m_owner] || m_cnt == TIMEOUT - 1) begin
      m_terr = !d && r[m_owner];
      m_last = m_owner;
      w = next_winner(m_last, r);
      m_cnt = 0;
      if (w >= 0) m_owner = w;
      else m_busy = 0;
    end else begin
      m_terr = 0;
      m_cnt++;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_gnt;
    exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    checks++;
    assert (gnt === exp_gnt) else begin
      errors++;
      $error("FAIL gnt: observed %b expected %b at %0t", gnt, exp_gnt, $time);
    end
    checks++;
    assert (sel === 2'(m_owner)) else begin
      errors++;
      $error("FAIL sel: observed %0d expected %0d at %0t", sel, m_owner, $time);
    end
    checks++;
    assert (busy === m_busy) else begin
      errors++;
      $error("FAIL busy: observed %b expected %b at %0t", busy, m_busy, $time);
    end
    checks++;
    assert (timeout_err === m_terr) else begin
      errors++;
      $error("FAIL timeout_err: observed %b expected %b at %0t", timeout_err, m_terr,
             $time);
    end
  endtask

  // Apply inputs, clock once, then compare DUT against the model 1 time unit later.
  task automatic step(input logic [3:0] r, input logic d, input logic l, input logic rn);
    req = r; done = d; lock = l; rst_n = rn;
    model_edge(r, d, l, rn);
    @(posedge clk);
    #1;
    if (m_terr) tmo_pulses++;
    check_outputs();
  endtask

  initial begin
    errors = 0; checks = 0; tmo_pulses = 0;
    m_busy = 0; m_owner = 0; m_last = 3; m_cnt = 0; m_terr = 0;
    req = 4'b0; done = 1'b0; lock = 1'b0; rst_n = 1'b0;
    #1;

    // Reset
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);

    // Single requester 0, done three cycles after the grant
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);   // done in idle is ignored

    // All requesting, done every second cycle: 1,2,3,0,1 ...
    for (int i = 0; i < 12; i++) step(4'b1111, 1'(i % 2), 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);

    // Only requester 2, back-to-back re-grants
    for (int i = 0; i < 6; i++) step(4'b0100, 1'(i % 2), 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // Watchdog: requester 0 hogs with 0011 held and no done
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    tmo_pulses = 0;
    for (int i = 0; i < 18; i++) step(4'b0011, 1'b0, 1'b0, 1'b1);
    checks++;
    assert (tmo_pulses == 1) else begin
      errors++;
      $error("FAIL tmo_count: observed %0d expected 1", tmo_pulses);
    end
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // Requester 3 withdraws; pending requester 1 follows; then reset mid-grant
    step(4'b1000, 1'b0, 1'b0, 1'b1);
    step(4'b1010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

`ifdef ARB_LOCK_EN
    // Lock keeps requester 0 across one done, then releases to requester 2
    step(4'b0101, 1'b0, 1'b0, 1'b1);
    step(4'b0101, 1'b1, 1'b1, 1'b1);
    step(4'b0101, 1'b0, 1'b0, 1'b1);
    step(4'b0101, 1'b1, 1'b0, 1'b1);
    checks++;
    assert (gnt === 4'b0100) else begin
      errors++;
      $error("FAIL lock_release: observed %b expected 0100", gnt);
    end
    step(4'b0000, 1'b1, 1'b0, 1'b1);
`endif

    // Random traffic with sticky requests, sparse done and rare resets
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      r = (($urandom_range(0, 3) == 0) ? 4'($urandom) : req);
      step(r, ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 60) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
